fp_normalize: RTL and testbench
===============================

FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL have parameter WIDTH, default 24, which is the output significand width including the hidden bit.
REQ-002 SHALL have parameter IN_WIDTH, default 48, which is the unnormalized input significand width; IN_WIDTH >= WIDTH+2.
REQ-003 SHALL have parameter EXP_WIDTH, default 10, which is the unsigned biased exponent width.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL provide port in_valid, input, 1 bit: an upstream operand is present.
REQ-007 SHALL provide port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-008 SHALL provide port in_sig, input, IN_WIDTH bits: the unnormalized significand.
REQ-009 SHALL provide port in_exp, input, EXP_WIDTH bits: the biased exponent of in_sig[IN_WIDTH-1].
REQ-010 SHALL provide port in_sign, input, 1 bit: the operand sign.
REQ-011 SHALL provide port in_sticky, input, 1 bit: OR of bits already discarded upstream.
REQ-012 SHALL provide port out_valid, output, 1 bit: a result is present.
REQ-013 SHALL provide port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL provide port out_sig, output, WIDTH bits: the normalized significand fed to the rounding stage.
REQ-015 SHALL provide port out_round, output, 1 bit: the first bit below out_sig.
REQ-016 SHALL provide port out_sticky, output, 1 bit: OR of all lower discarded bits and in_sticky.
REQ-017 SHALL provide port out_exp, output, EXP_WIDTH bits: the adjusted exponent.
REQ-018 SHALL provide port out_sign, output, 1 bit: in_sign passed through.
REQ-019 SHALL provide port out_zero, output, 1 bit: in_sig was all zeros.

Function
REQ-020 SHALL be a two-stage pipeline: S1 registers the operand plus lzc, the leading-zero count of in_sig (0..IN_WIDTH); S2 registers the shifted result.
REQ-021 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-022 SHALL compute s2_ready = !s2_valid || out_ready and in_ready = !s1_valid || s2_ready, giving throughput of 1 per cycle and no combinational in_valid->out_valid path.
REQ-023 SHALL, with out_ready held at 1, assert out_valid exactly 2 cycles after the input handshake.
REQ-024 SHALL hold all out_* signals stable while out_valid && !out_ready.
REQ-025 SHALL, when in_exp > lzc, use shift = lzc and out_exp = in_exp - lzc.
REQ-026 SHALL, when in_exp <= lzc (subnormal), use shift = (in_exp==0) ? 0 : in_exp-1 and out_exp = 0.
REQ-027 SHALL form t = in_sig << shift and output out_sig = t[IN_WIDTH-1 -: WIDTH], out_round = t[IN_WIDTH-WIDTH-1], and out_sticky = |t[IN_WIDTH-WIDTH-2:0] | in_sticky.
REQ-028 SHALL, when in_sig == 0, output out_zero = 1, out_sig = 0, out_round = 0, out_exp = 0, and out_sticky = in_sticky.
REQ-029 SHALL capture S1 and S2 simultaneously in one cycle when both stages advance, with no bubble and no data loss.
REQ-030 SHALL ignore in_* while in_ready = 0, and SHALL NOT mutate data registers of a stage that is not advancing.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear s1_valid and s2_valid, so out_valid = 0 and in_ready = 1.
REQ-032 SHALL, on rst_n low, clear out_sig, out_round, out_sticky, out_exp, out_sign, and out_zero to 0.
REQ-033 SHALL discard in-flight operands on reset mid-operation; no result SHALL appear after rst_n returns high without a new input handshake.

Verification
REQ-034 SHALL cover: in_sig=48'h000001800001, in_exp=100, in_sticky=0 -> 2 cycles later out_sig=24'hC00000, out_round=1, out_sticky=0, out_exp=77.
REQ-035 SHALL cover: in_sig=48'h800000800000, in_exp=5 -> out_sig=24'h800000, out_round=1, out_sticky=0, out_exp=5.
REQ-036 SHALL cover: in_sig=48'h000001000000, in_exp=10 -> shift 9, out_sig=24'h000200, out_round=0, out_exp=0.
REQ-037 SHALL cover: in_sig=0, in_sticky=1, in_sign=1 -> out_zero=1, out_sig=0, out_sticky=1, out_sign=1.
REQ-038 SHALL cover: out_ready=0 with continuous in_valid -> exactly 2 operands accepted, in_ready=0 from the third cycle, outputs stable; on out_ready=1, results drain in order with one per cycle.
REQ-039 SHALL cover: rst_n pulsed low with both stages valid -> out_valid=0 and in_ready=1 immediately, and no stale result afterwards.

Source files
------------

// File: rtl/fp_normalize.sv
// Two-stage significand normalizer: S1 captures the operand and its leading-zero
// count, S2 shifts left and registers the rounding-ready significand.
module fp_normalize #(
    parameter int WIDTH     = 24,
    parameter int IN_WIDTH  = 48,
    parameter int EXP_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_sig,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic                 in_sign,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sig,
    output logic                 out_round,
    output logic                 out_sticky,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_sign,
    output logic                 out_zero
);

    localparam int LZW = $clog2(IN_WIDTH + 1);
    localparam int CW  = ((EXP_WIDTH > LZW) ? EXP_WIDTH : LZW) + 1;

    logic                 s1_valid;
    logic [IN_WIDTH-1:0]  s1_sig;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic                 s1_sign;
    logic                 s1_sticky;
    logic [LZW-1:0]       s1_lzc;
    logic                 s2_valid;
    logic                 s2_ready;
    logic [LZW-1:0]       lzc;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    // Last hit wins, so the highest set bit determines the count.
    always_comb begin
        lzc = LZW'(IN_WIDTH);
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (in_sig[i]) lzc = LZW'(IN_WIDTH - 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sig    <= '0;
            s1_exp    <= '0;
            s1_sign   <= 1'b0;
            s1_sticky <= 1'b0;
            s1_lzc    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sig    <= in_sig;
                s1_exp    <= in_exp;
                s1_sign   <= in_sign;
                s1_sticky <= in_sticky;
                s1_lzc    <= lzc;
            end
        end
    end

    logic [CW-1:0]        exp_w;
    logic [CW-1:0]        lzc_w;
    logic [LZW-1:0]       shift;
    logic [EXP_WIDTH-1:0] nexp;
    logic                 is_zero;
    logic [IN_WIDTH-1:0]  t;

    assign exp_w   = CW'(s1_exp);
    assign lzc_w   = CW'(s1_lzc);
    assign is_zero = (s1_sig == '0);

    // Subnormal targets stop shifting once the exponent would reach 1.
    always_comb begin
        shift = '0;
        nexp  = '0;
        if (is_zero) begin
            shift = '0;
            nexp  = '0;
        end else if (exp_w > lzc_w) begin
            shift = s1_lzc;
            nexp  = EXP_WIDTH'(exp_w - lzc_w);
        end else if (s1_exp != '0) begin
            shift = LZW'(exp_w - CW'(1));
        end
    end

    assign t = s1_sig << shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_sig    <= '0;
            out_round  <= 1'b0;
            out_sticky <= 1'b0;
            out_exp    <= '0;
            out_sign   <= 1'b0;
            out_zero   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sig    <= t[IN_WIDTH-1 -: WIDTH];
                out_round  <= t[IN_WIDTH-WIDTH-1];
                out_sticky <= (|t[IN_WIDTH-WIDTH-2:0]) | s1_sticky;
                out_exp    <= nexp;
                out_sign   <= s1_sign;
                out_zero   <= is_zero;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// Directed bench for fp_normalize: scoreboard against an arithmetic model,
// plus literal checks on the documented vectors, stall and reset behaviour.
module tb_fp_normalize;

    typedef struct packed {
        logic [23:0] sig;
        logic        rnd;
        logic        sticky;
        logic [9:0]  exp;
        logic        sign;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_sig;
    logic [9:0]  in_exp;
    logic        in_sign;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sig;
    logic        out_round;
    logic        out_sticky;
    logic [9:0]  out_exp;
    logic        out_sign;
    logic        out_zero;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    res_t exp_q[$];

    fp_normalize #(.WIDTH(24), .IN_WIDTH(48), .EXP_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sig(in_sig), .in_exp(in_exp),
        .in_sign(in_sign), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sig(out_sig), .out_round(out_round),
        .out_sticky(out_sticky), .out_exp(out_exp),
        .out_sign(out_sign), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Normalize by locating the leading one, then clamp at the subnormal floor.
    function automatic res_t model(input logic [47:0] sig, input logic [9:0] e,
                                   input logic sg, input logic st);
        res_t r;
        int msb;
        int lz;
        int sh;
        int oe;
        logic [47:0] t;
        msb = -1;
        for (int i = 47; i >= 0; i--) begin
            if (sig[i]) begin
                msb = i;
                break;
            end
        end
        lz = 47 - msb;
        if (msb < 0) begin
            sh = 0;
            oe = 0;
        end else if (int'(e) > lz) begin
            sh = lz;
            oe = int'(e) - lz;
        end else begin
            sh = (e == 0) ? 0 : int'(e) - 1;
            oe = 0;
        end
        t = sig << sh;
        r.sig = t[47:24];
        r.rnd = t[23];
        r.sticky = (|t[22:0]) | st;
        r.exp = 10'(oe);
        r.sign = sg;
        r.zero = (msb < 0);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.sig = out_sig;
        r.rnd = out_round;
        r.sticky = out_sticky;
        r.exp = out_exp;
        r.sign = out_sign;
        r.zero = out_zero;
        return r;
    endfunction

    // Scoreboard and hold-stable checker, sampled on the falling edge.
    res_t prev_out;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", 64'(dut_res()), 64'(prev_out));
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sig, in_exp, in_sign, in_sticky));
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_result", 64'(dut_res()), 64'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = dut_res();
        end
    end

    task automatic drive(input logic [47:0] s, input logic [9:0] e,
                         input logic sg, input logic st);
        in_sig = s;
        in_exp = e;
        in_sign = sg;
        in_sticky = st;
    endtask

    task automatic run_one(input string name, input logic [47:0] s,
                           input logic [9:0] e, input logic sg,
                           input logic st, input res_t req);
        int k;
        @(posedge clk);
        #1;
        drive(s, e, sg, st);
        in_valid = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                k = i;
                break;
            end
        end
        chk({name, "_latency"}, 64'(k), 64'(2));
        chk({name, "_literal"}, 64'(dut_res()), 64'(req));
    endtask

    logic [47:0] v_sig [8] = '{48'h000001800001, 48'h800000800000,
                               48'h000001000000, 48'h0,
                               48'hFFFFFFFFFFFF, 48'h000000000001,
                               48'h000000FFFFFF, 48'h00F000000003};
    logic [9:0]  v_exp [8] = '{10'd100, 10'd5, 10'd10, 10'd900,
                               10'd0, 10'd1, 10'd24, 10'd8};
    logic        v_sg  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        v_st  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    res_t r034 = '{sig: 24'hC00000, rnd: 1'b1, sticky: 1'b0, exp: 10'd77,
                   sign: 1'b0, zero: 1'b0};
    res_t r035 = '{sig: 24'h800000, rnd: 1'b1, sticky: 1'b0, exp: 10'd5,
                   sign: 1'b0, zero: 1'b0};
    res_t r036 = '{sig: 24'h000200, rnd: 1'b0, sticky: 1'b0, exp: 10'd0,
                   sign: 1'b0, zero: 1'b0};
    res_t r037 = '{sig: 24'h0, rnd: 1'b0, sticky: 1'b1, exp: 10'd0,
                   sign: 1'b1, zero: 1'b1};

    initial begin
        int idx;
        int base;
        int guard;
        logic hs;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(48'h0, 10'd0, 1'b0, 1'b0);

        chk("model_034", 64'(model(48'h000001800001, 10'd100, 1'b0, 1'b0)),
            64'(r034));
        chk("model_035", 64'(model(48'h800000800000, 10'd5, 1'b0, 1'b0)),
            64'(r035));
        chk("model_036", 64'(model(48'h000001000000, 10'd10, 1'b0, 1'b0)),
            64'(r036));
        chk("model_037", 64'(model(48'h0, 10'd7, 1'b1, 1'b1)), 64'(r037));

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_outputs", 64'(dut_res()), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_one("v034", 48'h000001800001, 10'd100, 1'b0, 1'b0, r034);
        run_one("v035", 48'h800000800000, 10'd5, 1'b0, 1'b0, r035);
        run_one("v036", 48'h000001000000, 10'd10, 1'b0, 1'b0, r036);
        run_one("v037", 48'h0, 10'd7, 1'b1, 1'b1, r037);

        // Back-to-back stream with out_ready held high, then random backpressure.
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk);
            #1;
            idx = 0;
            drive(v_sig[0], v_exp[0], v_sg[0], v_st[0]);
            in_valid = 1'b1;
            guard = 0;
            while (idx < 8 && guard < 200) begin
                if (pass == 1) out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                hs = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (hs) begin
                    idx++;
                    if (idx < 8) drive(v_sig[idx], v_exp[idx], v_sg[idx], v_st[idx]);
                end
                guard++;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk("stream_sent", 64'(idx), 64'(8));
            repeat (4) @(posedge clk);
            #1;
            chk("stream_drained", 64'(exp_q.size()), 64'(0));
        end

        // Stall: only two operands fit while the output is blocked.
        out_ready = 1'b0;
        idx = 0;
        drive(v_sig[0], v_exp[0], v_sg[0], v_st[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) chk("stall_in_ready", 64'(in_ready), 64'(0));
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                drive(v_sig[idx], v_exp[idx], v_sg[idx], v_st[idx]);
            end
        end
        chk("stall_accepted", 64'(idx), 64'(2));
        out_ready = 1'b1;
        base = out_cnt;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < 4) drive(v_sig[idx], v_exp[idx], v_sg[idx], v_st[idx]);
                else in_valid = 1'b0;
            end
        end
        chk("drain_rate", 64'(out_cnt - base), 64'(4));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_drained", 64'(exp_q.size()), 64'(0));

        // Reset with both stages full.
        out_ready = 1'b0;
        drive(v_sig[4], v_exp[4], v_sg[4], v_st[4]);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("full_before_reset", 64'({out_valid, in_ready}), 64'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_outputs", 64'(dut_res()), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        base = out_cnt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale_valid", 64'(out_valid), 64'(0));
        end
        chk("no_stale_count", 64'(out_cnt - base), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
